// File: rtl/fifo_readout_arb_pkg.sv
// Shared definitions for the FIFO readout sequencer: state encoding, frame
// markers and the channel index width.
package fifo_readout_arb_pkg;

  localparam int          CH_W       = 2;
  localparam logic [7:0]  HDR_MARK   = 8'hA5;
  localparam logic [31:0] ABORT_WORD = 32'hDEADDEAD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_HDR,
    ST_REQ,
    ST_PUSH,
    ST_ABORT
  } state_t;

  function automatic logic [31:0] hdr_word(input logic [CH_W-1:0] ch,
                                           input logic [15:0]     len);
    return {HDR_MARK, 6'b0, ch, len};
  endfunction

endpackage

// File: rtl/fifo_readout_arb_rr_arbiter4.sv
// Combinational round-robin pick over four requests, searching upward from
// the slot after ptr and wrapping back to ptr itself last.
module rr_arbiter4
  import fifo_readout_arb_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt,
  output logic            any_vld
);

  // Walk from lowest to highest priority so the nearest requester wins.
  always_comb begin
    gnt     = ptr;
    any_vld = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr + CH_W'(i)]) begin
        gnt     = ptr + CH_W'(i);
        any_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_readout_arb.sv
// Round-robin readout sequencer: pulls bursts from four Wishbone FIFO read
// ports and emits them as header-framed words on a 32-bit valid/ready stream.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for enable and a nonzero FIFO count
//   ARB      | pick next channel, latch burst length, build header
//   HDR      | presenting header word on the stream
//   REQ      | Wishbone read on the granted channel, ack timer running
//   PUSH     | presenting one data word on the stream
//   ABORT    | presenting the abort word that closes a truncated frame
module fifo_readout_arb
  import fifo_readout_arb_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 enable,
  input  logic [NCH*CNT_W-1:0] fifo_cnt,
  output logic [NCH-1:0]       fifo_cyc,
  output logic [NCH-1:0]       fifo_stb,
  input  logic [NCH-1:0]       fifo_ack,
  input  logic [NCH*32-1:0]    fifo_dat,
  output logic [31:0]          out_dat,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 out_last,
  output logic                 busy,
  output logic [CH_W-1:0]      cur_ch,
  output logic                 err_timeout,
  input  logic                 clr_err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gnt_ch;
  logic              any_req;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [NCH-1:0]    elig;
  logic [CNT_W-1:0]  cnt_arr [NCH];
  logic [31:0]       dat_arr [NCH];
  logic [15:0]       len_sel;
  logic              ack_sel;
  logic              last_word;
  logic              tmo_done;

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign cnt_arr[k] = fifo_cnt[k*CNT_W +: CNT_W];
    assign dat_arr[k] = fifo_dat[k*32 +: 32];
    assign elig[k]    = |cnt_arr[k];
  end

  rr_arbiter4 u_rr (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt_ch),
    .any_vld (any_req)
  );

  always_comb begin
    if (32'(cnt_arr[gnt_ch]) > 32'(MAX_BURST)) len_sel = 16'(MAX_BURST);
    else                                       len_sel = 16'(cnt_arr[gnt_ch]);
  end

  assign ack_sel   = fifo_ack[cur_ch];
  assign last_word = (word_cnt == len - 16'd1);
  assign tmo_done  = (tmo_cnt == '0);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    out_vld   = 1'b0;
    out_last  = 1'b0;
    fifo_cyc  = '0;
    case (state)
      ST_IDLE:  if (enable && (|elig)) state_nxt = ST_ARB;
      ST_ARB:   state_nxt = any_req ? ST_HDR : ST_IDLE;
      ST_HDR: begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        fifo_cyc[cur_ch] = 1'b1;
        if (ack_sel)       state_nxt = ST_PUSH;
        else if (tmo_done) state_nxt = ST_ABORT;
      end
      ST_PUSH: begin
        out_vld  = 1'b1;
        out_last = last_word;
        if (out_rdy) state_nxt = last_word ? ST_IDLE : ST_REQ;
      end
      ST_ABORT: begin
        out_vld  = 1'b1;
        out_last = 1'b1;
        if (out_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fifo_stb = fifo_cyc;

  // Ack timer is a down-counter reloaded each time a read is about to start.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rr_ptr   <= CH_W'(3);
      cur_ch   <= '0;
      len      <= '0;
      word_cnt <= '0;
      tmo_cnt  <= '0;
      out_dat  <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (any_req) begin
            rr_ptr   <= gnt_ch;
            cur_ch   <= gnt_ch;
            len      <= len_sel;
            word_cnt <= '0;
            out_dat  <= hdr_word(gnt_ch, len_sel);
          end
        end
        ST_HDR: begin
          if (out_rdy) tmo_cnt <= TMO_W'(TIMEOUT - 1);
        end
        ST_REQ: begin
          if (ack_sel)        out_dat <= dat_arr[cur_ch];
          else if (tmo_done)  out_dat <= ABORT_WORD;
          else                tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
        ST_PUSH: begin
          if (out_rdy) begin
            word_cnt <= word_cnt + 16'd1;
            tmo_cnt  <= TMO_W'(TIMEOUT - 1);
          end
        end
        default: ;
      endcase
    end
  end

  // A clear in the same cycle as a timeout leaves the flag low.
  always_ff @(posedge wb_clk) begin
    if (wb_rst)
      err_timeout <= 1'b0;
    else if (clr_err)
      err_timeout <= 1'b0;
    else if (state == ST_REQ && !ack_sel && tmo_done)
      err_timeout <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_readout_arb.sv
// Scoreboard bench for fifo_readout_arb: a FIFO responder model feeds data,
// a reference arbitration model predicts every stream word.
module tb_fifo_readout_arb;

  localparam int NCH = 4, CNT_W = 16, MAX_BURST = 16, TIMEOUT = 255;

  logic                 wb_clk = 1'b0;
  logic                 wb_rst = 1'b1;
  logic                 enable = 1'b0;
  logic [NCH*CNT_W-1:0] fifo_cnt;
  logic [NCH-1:0]       fifo_cyc, fifo_stb;
  logic [NCH-1:0]       fifo_ack = '0;
  logic [NCH*32-1:0]    fifo_dat = '0;
  logic [31:0]          out_dat;
  logic                 out_vld;
  logic                 out_rdy = 1'b1;
  logic                 out_last;
  logic                 busy;
  logic [1:0]           cur_ch;
  logic                 err_timeout;
  logic                 clr_err = 1'b0;

  typedef struct { logic [31:0] dat; logic last; } exp_t;
  exp_t sb_q[$];

  int n_chk = 0, n_err = 0, n_hs = 0, cyc2_cnt = 0, mptr = 3;
  int level[NCH], rseq[NCH], mseq[NCH], ack_cnt[NCH];
  bit ack_en[NCH];

  always #5 wb_clk = ~wb_clk;

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    assign fifo_cnt[k*CNT_W +: CNT_W] = CNT_W'(level[k]);
  end

  fifo_readout_arb #(.NCH(NCH), .CNT_W(CNT_W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .fifo_cnt(fifo_cnt),
    .fifo_cyc(fifo_cyc), .fifo_stb(fifo_stb), .fifo_ack(fifo_ack), .fifo_dat(fifo_dat),
    .out_dat(out_dat), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .busy(busy), .cur_ch(cur_ch), .err_timeout(err_timeout), .clr_err(clr_err)
  );

  function automatic logic [31:0] data_word(int k, int s);
    return 32'hC000_0000 | (32'(k) << 24) | 32'(s & 32'hFFFF);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%08h expected=%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic push_exp(logic [31:0] d, logic l);
    exp_t e;
    e.dat = d; e.last = l;
    sb_q.push_back(e);
  endtask

  // Reference model of the whole readout for the current FIFO levels.
  task automatic predict();
    int lv[NCH];
    int ch, len, tot;
    for (int k = 0; k < NCH; k++) lv[k] = level[k];
    tot = lv[0] + lv[1] + lv[2] + lv[3];
    while (tot > 0) begin
      ch = -1;
      for (int i = 1; i <= NCH; i++)
        if (ch < 0 && lv[(mptr + i) % NCH] > 0) ch = (mptr + i) % NCH;
      mptr = ch;
      len  = (lv[ch] < MAX_BURST) ? lv[ch] : MAX_BURST;
      push_exp(32'hA500_0000 | (32'(ch) << 16) | 32'(len), 1'b0);
      for (int i = 0; i < len; i++) begin
        push_exp(data_word(ch, mseq[ch]), i == len - 1);
        mseq[ch]++;
      end
      lv[ch] -= len;
      tot    -= len;
    end
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    step();
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    #3;
    chk({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    step();
    wb_rst = 1'b1;
    enable = 1'b0;
    step(2);
    wb_rst = 1'b0;
    mptr = 3;
    sb_q.delete();
    for (int k = 0; k < NCH; k++) mseq[k] = rseq[k];
  endtask

  task automatic run_frames(string tag, int l0, int l1, int l2, int l3);
    level[0] = l0; level[1] = l1; level[2] = l2; level[3] = l3;
    predict();
    enable = 1'b1;
    drain(tag, 4000);
    enable = 1'b0;
  endtask

  // FIFO read-port responder: one-cycle ack, one word per ack.
  always @(negedge wb_clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (fifo_cyc[k] && fifo_stb[k] && !fifo_ack[k] && ack_en[k]) begin
        fifo_ack[k] = 1'b1;
        fifo_dat[k*32 +: 32] = data_word(k, rseq[k]);
        rseq[k]++;
        ack_cnt[k]++;
        if (level[k] > 0) level[k]--;
      end else begin
        fifo_ack[k] = 1'b0;
      end
    end
  end

  // Stream monitor: every accepted word is checked against the scoreboard.
  always begin
    exp_t e;
    @(negedge wb_clk);
    #3;
    if (fifo_cyc[2]) cyc2_cnt++;
    if (!wb_rst && out_vld && out_rdy) begin
      n_hs++;
      chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("out_dat", out_dat, e.dat);
        chk("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    for (int k = 0; k < NCH; k++) begin
      level[k] = 0; rseq[k] = 0; mseq[k] = 0; ack_cnt[k] = 0; ack_en[k] = 1'b1;
    end
    step(3);
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_cyc", 32'(fifo_cyc), 32'd0);
    chk("rst_stb", 32'(fifo_stb), 32'd0);
    chk("rst_dat", out_dat, 32'd0);
    chk("rst_ch", 32'(cur_ch), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    step();
    wb_rst = 1'b0;

    // single channel burst of three
    run_frames("a3", 3, 0, 0, 0);
    chk("a3_acks", 32'(ack_cnt[0]), 32'd3);

    // one word on every channel, channel 0 first after reset
    do_reset();
    run_frames("all1", 1, 1, 1, 1);

    // burst splitting and alternation
    do_reset();
    for (int k = 0; k < NCH; k++) ack_cnt[k] = 0;
    run_frames("a40b5", 40, 5, 0, 0);
    chk("a40b5_acks0", 32'(ack_cnt[0]), 32'd40);
    chk("a40b5_acks1", 32'(ack_cnt[1]), 32'd5);

    // backpressure while a data word is held
    n_hs = 0;
    level[0] = 4;
    predict();
    enable = 1'b1;
    n = 0;
    while (n_hs < 2 && n < 500) begin step(); n++; end
    out_rdy = 1'b0;
    n = 0;
    while (!out_vld && n < 500) begin step(); n++; end
    for (int i = 0; i < 10; i++) begin
      step();
      #3;
      chk("bp_dat", out_dat, (sb_q.size() != 0) ? sb_q[0].dat : 32'hFFFF_FFFF);
      chk("bp_vld", 32'(out_vld), 32'd1);
      chk("bp_stb", 32'(fifo_stb), 32'd0);
    end
    step();
    out_rdy = 1'b1;
    drain("bp", 2000);
    enable = 1'b0;

    // ack timeout on channel 2
    ack_en[2] = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      step();
      cyc2_cnt = 0;
      clr_err  = (pass == 1);
      level[2] = 1;
      mptr     = 2;
      push_exp(32'hA502_0001, 1'b0);
      push_exp(32'hDEAD_DEAD, 1'b1);
      enable = 1'b1;
      n = 0;
      while (!busy && n < 100) begin step(); n++; end
      enable = 1'b0;
      drain(pass == 0 ? "tmo" : "tmo_clr", 1000);
      level[2] = 0;
      chk("tmo_cyc_cycles", 32'(cyc2_cnt), 32'd255);
      chk("tmo_err", 32'(err_timeout), (pass == 0) ? 32'd1 : 32'd0);
      if (pass == 0) begin
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        #3;
        chk("tmo_clr_err", 32'(err_timeout), 32'd0);
      end
      clr_err = 1'b0;
    end
    ack_en[2] = 1'b1;

    // reset pulsed during a read request
    do_reset();
    level[0] = 5; level[1] = 3;
    predict();
    enable = 1'b1;
    n = 0;
    while (!fifo_cyc[0] && n < 100) begin step(); n++; end
    chk("rreq_seen", 32'(fifo_cyc), 32'd1);
    wb_rst = 1'b1;
    step();
    #3;
    chk("rreq_cyc", 32'(fifo_cyc), 32'd0);
    chk("rreq_stb", 32'(fifo_stb), 32'd0);
    chk("rreq_vld", 32'(out_vld), 32'd0);
    chk("rreq_busy", 32'(busy), 32'd0);
    chk("rreq_dat", out_dat, 32'd0);
    step();
    enable = 1'b0;
    wb_rst = 1'b0;
    mptr = 3;
    sb_q.delete();
    for (int k = 0; k < NCH; k++) mseq[k] = rseq[k];
    run_frames("post_rst", level[0], level[1], level[2], level[3]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_readout_arb.md
Name: fifo_readout_arb

Overview:
- Round-robin readout sequencer for the four channel receive FIFOs (A-D).
- Acts as a Wishbone master on each FIFO's read port, using the FIFO word counts to choose the next channel.
- Moves bursts of words into a single framed 32-bit valid/ready stream for downstream event building or VME block readout.
- Replaces word-by-word CPU polling of the per-channel count registers.

Parameters:
- NCH, 4: number of FIFO channels; channel index width is 2.
- CNT_W, 16: width of each FIFO word-count input.
- MAX_BURST, 16: maximum data words read per grant; range 1..65535.
- TIMEOUT, 255: wb_clk cycles to wait for a FIFO ack before aborting.

Ports:
- wb_clk  in  1  Wishbone clock, sole clock of the block.
- wb_rst  in  1  synchronous reset, active high.
- enable  in  1  allows new grants; sampled only in IDLE.
- fifo_cnt  in  NCH*CNT_W  per-channel readable word count; channel k occupies bits [k*CNT_W +: CNT_W].
- fifo_cyc  out  NCH  per-channel Wishbone cyc, one-hot or zero.
- fifo_stb  out  NCH  per-channel Wishbone stb, equal to fifo_cyc.
- fifo_ack  in  NCH  per-channel Wishbone ack.
- fifo_dat  in  NCH*32  per-channel read data; channel k occupies bits [k*32 +: 32].
- out_dat  out  32  stream data.
- out_vld  out  1  stream valid.
- out_rdy  in  1  stream ready.
- out_last  out  1  marks the last word of a frame.
- busy  out  1  high whenever state is not IDLE.
- cur_ch  out  2  channel currently or last granted.
- err_timeout  out  1  sticky ack-timeout flag.
- clr_err  in  1  clears err_timeout.

Behaviour:
- Reset (wb_rst=1 at a wb_clk edge) forces every output to 0, state to IDLE, and rr_ptr to 3 so channel 0 has first priority.
- Reset mid-burst drops cyc/stb on the next edge; any partial frame is abandoned.
- A channel is eligible when its fifo_cnt is nonzero.

State machine:
- IDLE: if enable and any channel is eligible, go to ARB.
- ARB (1 cycle):
  - Grant the first eligible channel in order rr_ptr+1, rr_ptr+2, ... (mod 4); set rr_ptr and cur_ch to it.
  - Latch len = min(fifo_cnt[ch], MAX_BURST) as 16 bits; clear the word counter.
  - Go to HDR.
- HDR:
  - Drive out_dat = {8'hA5, 6'b0, ch[1:0], len[15:0]}, out_vld=1, out_last=0.
  - On out_vld && out_rdy, go to REQ.
- REQ:
  - Assert fifo_cyc[ch] and fifo_stb[ch]; count idle cycles.
  - On fifo_ack[ch]: register fifo_dat[ch] into out_dat, drop cyc/stb the same edge, go to PUSH.
  - If the count reaches TIMEOUT without ack: drop cyc/stb, set err_timeout, go to ABORT.
- PUSH:
  - out_vld=1; out_last=1 if this is word len-1.
  - On out_rdy: increment the counter; go to IDLE if this was the last word, else REQ.
  - Minimum 2 cycles per data word; no new read is issued while a word is held.
- ABORT:
  - Drive out_dat=32'hDEADDEAD, out_vld=1, out_last=1.
  - On out_rdy, go to IDLE.

Stream and error rules:
- out_dat, out_vld and out_last hold stable while out_vld && !out_rdy.
- A frame is always 1 header word plus len data words, or a truncated frame closed by the ABORT word.
- enable going low mid-burst does not stop the current frame.
- Changes to fifo_cnt after ARB are ignored until the next ARB.
- An ack on a non-granted channel is ignored.
- clr_err takes priority over a same-cycle timeout set: the result is 0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ARB, HDR, REQ, PUSH, ABORT);
  - header marker 8'hA5;
  - abort word 32'hDEADDEAD;
  - channel index width.
- One natural sub-module, rr_arbiter4: combinational round-robin priority pick from a 4-bit request vector and 2-bit pointer, returning grant index and any-valid.

Test Plan:
- fifo_cnt A=3, others 0, out_rdy=1 -> stream A5000003, 3 A-words, last on word 3; exactly 3 acks on fifo_cyc[0]; busy returns to 0.
- All four counts=1 -> frames in order ch0, ch1, ch2, ch3 with headers A5000001, A5010001, A5020001, A5030001.
- A=40, B=5, MAX_BURST=16 -> frames A16, B5, A16, A8 in that order.
- out_rdy low 10 cycles during a data word -> out_dat held, no new stb issued, no word lost or duplicated.
- fifo_ack never asserted on channel 2 -> stb drops after 255 cycles, err_timeout=1, DEADDEAD with out_last; clr_err clears the flag.
- wb_rst pulsed during REQ -> next cycle all outputs 0; after reset, channel 0 is granted first.
